// File: rtl/echo_receiver_pkg.sv
// Shared constants and FSM encoding for the ultrasonic echo receiver.
// Timing defaults are common with the Trigger block.
package echo_receiver_pkg;

  localparam int unsigned DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_CYCLES_PER_CM = 2900;
  localparam int unsigned DEF_ARM_TIMEOUT   = 1_000_000;
  localparam int unsigned DEF_ECHO_MAX      = 1_900_000;
  localparam int unsigned DEF_CNT_W         = 21;
  localparam int unsigned DEF_CM_W          = 9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    MEASURE  = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous pin
// with registered rise/fall detection.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~prev;
  assign fall  = ~s2 & prev;

endmodule

// File: rtl/echo_receiver.sv
// Measures the echo pulse answering each trigger and
// converts its width to centimetres.
module echo_receiver #(
  parameter int unsigned CYCLES_PER_CM = echo_receiver_pkg::DEF_CYCLES_PER_CM,
  parameter int unsigned ARM_TIMEOUT   = echo_receiver_pkg::DEF_ARM_TIMEOUT,
  parameter int unsigned ECHO_MAX      = echo_receiver_pkg::DEF_ECHO_MAX,
  parameter int unsigned CNT_W         = echo_receiver_pkg::DEF_CNT_W,
  parameter int unsigned CM_W          = echo_receiver_pkg::DEF_CM_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic             echo,
  output logic [CM_W-1:0]  distance_cm,
  output logic [CNT_W-1:0] pulse_cycles,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);

  import echo_receiver_pkg::*;

  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ECHO_LIM = CNT_W'(ECHO_MAX);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CYCLES_PER_CM - 1);

  state_t state, state_d;

  logic             trig_q;
  logic             arm;
  logic             lvl, rise, fall;
  logic [CNT_W-1:0] arm_cnt;
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] pre;
  logic [CM_W-1:0]  cm;
  logic             arm_to, done, ovf;

  sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .level (lvl),
    .rise  (rise),
    .fall  (fall)
  );

  assign arm = trig_q & ~trigger;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (arm) state_d = ARMED;
      ARMED: begin
        if (rise)        state_d = MEASURE;
        else if (arm_to) state_d = IDLE;
      end
      MEASURE: begin
        if (fall)     state_d = IDLE;
        else if (ovf) state_d = WAIT_LOW;
      end
      WAIT_LOW: if (!lvl) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // A rise or a re-arm in the same cycle beats the arm timeout;
  // a fall beats the overflow.
  always_comb begin
    arm_to = (state == ARMED) & ~rise & ~arm & (arm_cnt == ARM_LAST);
    done   = (state == MEASURE) & fall;
    ovf    = (state == MEASURE) & ~fall & lvl & (cyc == ECHO_LIM);
    busy   = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q       <= 1'b0;
      arm_cnt      <= '0;
      cyc          <= '0;
      pre          <= '0;
      cm           <= '0;
      distance_cm  <= '0;
      pulse_cycles <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      trig_q  <= trigger;
      valid   <= done;
      timeout <= arm_to | ovf;
      if (done) begin
        pulse_cycles <= cyc;
        distance_cm  <= cm;
      end else if (ovf) begin
        pulse_cycles <= ECHO_LIM;
        distance_cm  <= '1;
      end
      unique case (state)
        IDLE: if (arm) arm_cnt <= '0;
        ARMED: begin
          // The rise cycle already saw echo high, so count it.
          if (rise) begin
            cyc <= CNT_W'(1);
            pre <= CNT_W'(1);
            cm  <= '0;
          end else if (arm) begin
            arm_cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (!fall && !ovf && lvl) begin
            cyc <= cyc + 1'b1;
            if (pre == PRE_LAST) begin
              pre <= '0;
              if (cm != '1) cm <= cm + 1'b1;
            end else begin
              pre <= pre + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
